// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one multi-cycle adder between NUM_REQ requesters.
// Define ADD_SAT_EN to saturate rsp_sum to all ones whenever the addition carries out.
module adder_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int ADD_LAT = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [WIDTH-1:0]           rsp_sum,
   output logic                       rsp_carry,
   output logic                       busy
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   id_q;
   logic [ID_W-1:0]   grant_idx;
   logic              grant_found;
   logic [CNT_W-1:0]  cnt;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH:0]    full_sum;
   logic [WIDTH-1:0]  sum_result;
   int                idx;

   // Descending scan so the candidate closest to rr_ptr is the last one written and wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (req_valid[ID_W'(idx)]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      busy      = (state != IDLE);
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_found) begin
               req_ready[grant_idx] = 1'b1;
               state_nxt            = BUSY;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            rsp_valid[id_q] = 1'b1;
            state_nxt       = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      full_sum = {1'b0, a_q} + {1'b0, b_q};
`ifdef ADD_SAT_EN
      sum_result = full_sum[WIDTH] ? '1 : full_sum[WIDTH-1:0];
`else
      sum_result = full_sum[WIDTH-1:0];
`endif
   end

   // Operands are captured at the handshake, so requesters may change them while BUSY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         id_q      <= '0;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_carry <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (grant_found) begin
                  a_q  <= req_a[grant_idx*WIDTH +: WIDTH];
                  b_q  <= req_b[grant_idx*WIDTH +: WIDTH];
                  id_q <= grant_idx;
                  cnt  <= CNT_W'(ADD_LAT - 1);
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  rsp_sum   <= sum_result;
                  rsp_carry <= full_sum[WIDTH];
                  rsp_id    <= id_q;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DONE: begin
               rr_ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
